// File: rtl/mfunc_dma_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mfunc_dma_pkg
//  Description : Shared types and helpers for the MFUNC copy-engine transfer
//                sequencer: FSM state encoding, default burst geometry
//                constants and the burst-length minimum helper.
//  Revision    : 1.0  initial release
// ============================================================================
package mfunc_dma_pkg;

  localparam int c_MAX_BURST_DEF = 256;
  localparam int c_LEN_W_DEF     = 13;
  localparam int c_BOUNDARY_DEF  = 4096;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CALC    = 3'd1,
    S_RD_CMD  = 3'd2,
    S_RD_WAIT = 3'd3,
    S_WR_CMD  = 3'd4,
    S_WR_WAIT = 3'd5,
    S_DONE    = 3'd6
  } dma_state_t;

  // Unsigned minimum on the full 64-bit address domain so boundary room
  // and byte counts can be compared without any truncation.
  function automatic logic [63:0] blen_min(input logic [63:0] a,
                                           input logic [63:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mfunc_dma_blen.sv
`default_nettype none
// ============================================================================
//  Module      : mfunc_dma_blen
//  Description : Combinational burst-length calculator. Picks the largest
//                burst that fits the remaining byte count, the maximum burst
//                size and, for each incrementing side, the distance to the
//                next address boundary.
//  Ports       : i_remaining  bytes still to move
//                i_src/i_dst  current source/destination addresses
//                i_rd_mode    1 = fixed source (no boundary limit on source)
//                i_wr_mode    1 = fixed destination (no boundary limit)
//                o_blen       resulting burst length, 1..MAX_BURST
//  Revision    : 1.0  initial release
// ============================================================================
module mfunc_dma_blen
  import mfunc_dma_pkg::*;
#(
  parameter int MAX_BURST = c_MAX_BURST_DEF,
  parameter int LEN_W     = c_LEN_W_DEF,
  parameter int BOUNDARY  = c_BOUNDARY_DEF
) (
  input  logic [31:0]      i_remaining,
  input  logic [63:0]      i_src,
  input  logic [63:0]      i_dst,
  input  logic             i_rd_mode,
  input  logic             i_wr_mode,
  output logic [LEN_W-1:0] o_blen
);

  localparam logic [63:0] c_BMASK = 64'(BOUNDARY - 1);
  localparam logic [63:0] c_BSIZE = 64'(BOUNDARY);
  localparam logic [63:0] c_MAXB  = 64'(MAX_BURST);

  logic [63:0] w_src_room;
  logic [63:0] w_dst_room;
  logic [63:0] w_lim;

  always_comb begin
    // Room left before the next boundary; an aligned address gets a full
    // BOUNDARY of room.
    w_src_room = c_BSIZE - (i_src & c_BMASK);
    w_dst_room = c_BSIZE - (i_dst & c_BMASK);
    w_lim      = blen_min({32'd0, i_remaining}, c_MAXB);
    if (!i_rd_mode) w_lim = blen_min(w_lim, w_src_room);
    if (!i_wr_mode) w_lim = blen_min(w_lim, w_dst_room);
    o_blen     = LEN_W'(w_lim);
  end

endmodule
`default_nettype wire

// File: rtl/mfunc_dma_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mfunc_dma_ctrl
//  Description : Transfer sequencer for the MFUNC copy engine. Latches the
//                programmed transfer on a rising start, splits it into
//                read/write burst command pairs issued strictly one after
//                the other, and raises a sticky done flag on completion.
//  Ports       : clk/rst               clock, synchronous active-high reset
//                params_*              register-block parameters and done
//                busy                  high in every state except IDLE
//                rd_cmd_* / rd_done    read mover command/completion
//                wr_cmd_* / wr_done    write mover command/completion
//                perf_cycles/bursts    only with MFUNC_DMA_PERF_EN defined
//  Build macro : MFUNC_DMA_PERF_EN adds busy-cycle and burst counters.
//  Revision    : 1.0  initial release
// ============================================================================
module mfunc_dma_ctrl
  import mfunc_dma_pkg::*;
#(
  parameter int MAX_BURST = c_MAX_BURST_DEF,
  parameter int LEN_W     = c_LEN_W_DEF,
  parameter int BOUNDARY  = c_BOUNDARY_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             params_start,
  input  logic [31:0]      params_saddr_l,
  input  logic [31:0]      params_saddr_h,
  input  logic [31:0]      params_daddr_l,
  input  logic [31:0]      params_daddr_h,
  input  logic [31:0]      params_data_len,
  input  logic             params_rd_mode,
  input  logic             params_wr_mode,
  output logic             params_data_done,
  output logic             busy,
  output logic             rd_cmd_valid,
  input  logic             rd_cmd_ready,
  output logic [63:0]      rd_cmd_addr,
  output logic [LEN_W-1:0] rd_cmd_len,
  input  logic             rd_done,
  output logic             wr_cmd_valid,
  input  logic             wr_cmd_ready,
  output logic [63:0]      wr_cmd_addr,
  output logic [LEN_W-1:0] wr_cmd_len,
  input  logic             wr_done
`ifdef MFUNC_DMA_PERF_EN
  ,
  output logic [31:0]      perf_cycles,
  output logic [15:0]      perf_bursts
`endif
);

  dma_state_t       r_state;
  logic             r_start_q;
  logic [63:0]      r_src;
  logic [63:0]      r_dst;
  logic [31:0]      r_rem;
  logic             r_rd_mode;
  logic             r_wr_mode;
  logic [LEN_W-1:0] r_blen;
  logic             r_done;
  logic             r_busy;
  logic             r_rd_valid;
  logic             r_wr_valid;

  logic             w_start_edge;
  logic             w_start_accept;
  logic [LEN_W-1:0] w_blen;
  logic [63:0]      w_blen64;

  assign w_start_edge   = params_start & ~r_start_q;
  assign w_start_accept = (r_state == S_IDLE) && w_start_edge;
  assign w_blen64       = 64'(r_blen);

  mfunc_dma_blen #(
    .MAX_BURST (MAX_BURST),
    .LEN_W     (LEN_W),
    .BOUNDARY  (BOUNDARY)
  ) u_blen (
    .i_remaining (r_rem),
    .i_src       (r_src),
    .i_dst       (r_dst),
    .i_rd_mode   (r_rd_mode),
    .i_wr_mode   (r_wr_mode),
    .o_blen      (w_blen)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_start_q  <= 1'b0;
      r_src      <= '0;
      r_dst      <= '0;
      r_rem      <= '0;
      r_rd_mode  <= 1'b0;
      r_wr_mode  <= 1'b0;
      r_blen     <= '0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
      r_rd_valid <= 1'b0;
      r_wr_valid <= 1'b0;
    end else begin
      r_start_q <= params_start;
      case (r_state)
        S_IDLE: begin
          if (w_start_edge) begin
            r_src     <= {params_saddr_h, params_saddr_l};
            r_dst     <= {params_daddr_h, params_daddr_l};
            r_rem     <= params_data_len;
            r_rd_mode <= params_rd_mode;
            r_wr_mode <= params_wr_mode;
            r_done    <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= (params_data_len == 32'd0) ? S_DONE : S_CALC;
          end
        end
        S_CALC: begin
          r_blen     <= w_blen;
          r_rd_valid <= 1'b1;
          r_state    <= S_RD_CMD;
        end
        S_RD_CMD: begin
          if (rd_cmd_ready) begin
            r_rd_valid <= 1'b0;
            r_state    <= S_RD_WAIT;
          end
        end
        S_RD_WAIT: begin
          if (rd_done) begin
            r_wr_valid <= 1'b1;
            r_state    <= S_WR_CMD;
          end
        end
        S_WR_CMD: begin
          if (wr_cmd_ready) begin
            r_wr_valid <= 1'b0;
            r_state    <= S_WR_WAIT;
          end
        end
        S_WR_WAIT: begin
          if (wr_done) begin
            r_rem <= r_rem - 32'(r_blen);
            if (!r_rd_mode) r_src <= r_src + w_blen64;
            if (!r_wr_mode) r_dst <= r_dst + w_blen64;
            r_state <= (r_rem == 32'(r_blen)) ? S_DONE : S_CALC;
          end
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy     <= 1'b0;
          r_rd_valid <= 1'b0;
          r_wr_valid <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

  assign params_data_done = r_done;
  assign busy             = r_busy;
  assign rd_cmd_valid     = r_rd_valid;
  assign rd_cmd_addr      = r_src;
  assign rd_cmd_len       = r_blen;
  assign wr_cmd_valid     = r_wr_valid;
  assign wr_cmd_addr      = r_dst;
  assign wr_cmd_len       = r_blen;

`ifdef MFUNC_DMA_PERF_EN
  logic [31:0] r_perf_cycles;
  logic [15:0] r_perf_bursts;

  // Counters freeze once the transfer returns to IDLE, so the values of the
  // last transfer stay readable until the next accepted start.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_cycles <= '0;
      r_perf_bursts <= '0;
    end else if (w_start_accept) begin
      r_perf_cycles <= '0;
      r_perf_bursts <= '0;
    end else begin
      if (r_busy && !(&r_perf_cycles))
        r_perf_cycles <= r_perf_cycles + 32'd1;
      if ((r_state == S_WR_WAIT) && wr_done && !(&r_perf_bursts))
        r_perf_bursts <= r_perf_bursts + 16'd1;
    end
  end

  assign perf_cycles = r_perf_cycles;
  assign perf_bursts = r_perf_bursts;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mfunc_dma_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_mfunc_dma_ctrl
//  Description : Scoreboard bench for mfunc_dma_ctrl. Directed transfers push
//                hand-computed read/write commands into queues; a monitor
//                pops and compares them at every command handshake. A mover
//                model answers with ready and done pulses.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mfunc_dma_ctrl;

  localparam int c_LEN_W = 13;

  logic               clk = 1'b0;
  logic               rst;
  logic               params_start;
  logic [31:0]        params_saddr_l, params_saddr_h;
  logic [31:0]        params_daddr_l, params_daddr_h;
  logic [31:0]        params_data_len;
  logic               params_rd_mode, params_wr_mode;
  logic               params_data_done;
  logic               busy;
  logic               rd_cmd_valid, rd_cmd_ready, rd_done;
  logic [63:0]        rd_cmd_addr;
  logic [c_LEN_W-1:0] rd_cmd_len;
  logic               wr_cmd_valid, wr_cmd_ready, wr_done;
  logic [63:0]        wr_cmd_addr;
  logic [c_LEN_W-1:0] wr_cmd_len;
`ifdef MFUNC_DMA_PERF_EN
  logic [31:0]        perf_cycles;
  logic [15:0]        perf_bursts;
`endif

  always #5 clk = ~clk;

  mfunc_dma_ctrl #(.MAX_BURST(256), .LEN_W(c_LEN_W), .BOUNDARY(4096)) dut (
    .clk              (clk),
    .rst              (rst),
    .params_start     (params_start),
    .params_saddr_l   (params_saddr_l),
    .params_saddr_h   (params_saddr_h),
    .params_daddr_l   (params_daddr_l),
    .params_daddr_h   (params_daddr_h),
    .params_data_len  (params_data_len),
    .params_rd_mode   (params_rd_mode),
    .params_wr_mode   (params_wr_mode),
    .params_data_done (params_data_done),
    .busy             (busy),
    .rd_cmd_valid     (rd_cmd_valid),
    .rd_cmd_ready     (rd_cmd_ready),
    .rd_cmd_addr      (rd_cmd_addr),
    .rd_cmd_len       (rd_cmd_len),
    .rd_done          (rd_done),
    .wr_cmd_valid     (wr_cmd_valid),
    .wr_cmd_ready     (wr_cmd_ready),
    .wr_cmd_addr      (wr_cmd_addr),
    .wr_cmd_len       (wr_cmd_len),
    .wr_done          (wr_done)
`ifdef MFUNC_DMA_PERF_EN
    ,
    .perf_cycles      (perf_cycles),
    .perf_bursts      (perf_bursts)
`endif
  );

  typedef struct packed {
    logic [63:0]        addr;
    logic [c_LEN_W-1:0] len;
  } cmd_t;

  cmd_t exp_rd_q[$];
  cmd_t exp_wr_q[$];

  int n_cmp     = 0;
  int n_err     = 0;
  int rd_hs_cnt = 0;
  int wr_hs_cnt = 0;
  int rd_stall  = 0;
  bit wr_done_block = 1'b0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_cmd(input logic [63:0] ra, input logic [63:0] wa,
                          input int len);
    cmd_t c;
    c.addr = ra; c.len = c_LEN_W'(len); exp_rd_q.push_back(c);
    c.addr = wa; exp_wr_q.push_back(c);
  endtask

  // Monitor: every handshake must match the head of its expected queue; a
  // stalled read command must already present the expected head values.
  initial begin : monitor
    cmd_t e;
    forever begin
      @(negedge clk);
      if (!rst && rd_cmd_valid) begin
        if (exp_rd_q.size() == 0) begin
          if (rd_cmd_ready) begin
            rd_hs_cnt++;
            n_cmp++; n_err++;
            $display("FAIL rd_unexpected: got cmd @0x%0h len 0x%0h, expected none",
                     rd_cmd_addr, rd_cmd_len);
          end
        end else if (rd_cmd_ready) begin
          rd_hs_cnt++;
          e = exp_rd_q.pop_front();
          chk("rd_addr", rd_cmd_addr, e.addr);
          chk("rd_len", 64'(rd_cmd_len), 64'(e.len));
        end else begin
          chk("rd_stall_addr", rd_cmd_addr, exp_rd_q[0].addr);
          chk("rd_stall_len", 64'(rd_cmd_len), 64'(exp_rd_q[0].len));
        end
      end
      if (!rst && wr_cmd_valid && wr_cmd_ready) begin
        wr_hs_cnt++;
        if (exp_wr_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL wr_unexpected: got cmd @0x%0h len 0x%0h, expected none",
                   wr_cmd_addr, wr_cmd_len);
        end else begin
          e = exp_wr_q.pop_front();
          chk("wr_addr", wr_cmd_addr, e.addr);
          chk("wr_len", 64'(wr_cmd_len), 64'(e.len));
        end
      end
    end
  end

  // Mover model: ready is high unless a read stall is pending; done pulses
  // follow the handshake immediately.
  initial begin : mover
    bit rd_hs, wr_hs, rd_v;
    rd_cmd_ready = 1'b1; wr_cmd_ready = 1'b1;
    rd_done = 1'b0; wr_done = 1'b0;
    forever begin
      @(negedge clk);
      rd_hs = rd_cmd_valid && rd_cmd_ready;
      wr_hs = wr_cmd_valid && wr_cmd_ready;
      rd_v  = rd_cmd_valid;
      @(posedge clk); #1;
      rd_done = rd_hs;
      wr_done = wr_hs && !wr_done_block;
      if (rd_v && !rd_hs && rd_stall > 0) rd_stall--;
      rd_cmd_ready = (rd_stall == 0);
    end
  end

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"},     64'(busy),             64'd0);
    chk({tag, "_done"},     64'(params_data_done), 64'd0);
    chk({tag, "_rd_valid"}, 64'(rd_cmd_valid),     64'd0);
    chk({tag, "_wr_valid"}, 64'(wr_cmd_valid),     64'd0);
    chk({tag, "_rd_addr"},  rd_cmd_addr,           64'd0);
    chk({tag, "_wr_addr"},  wr_cmd_addr,           64'd0);
    chk({tag, "_rd_len"},   64'(rd_cmd_len),       64'd0);
    chk({tag, "_wr_len"},   64'(wr_cmd_len),       64'd0);
  endtask

  task automatic set_params(input logic [63:0] s, input logic [63:0] d,
                            input logic [31:0] len, input bit rm, input bit wm);
    {params_saddr_h, params_saddr_l} = s;
    {params_daddr_h, params_daddr_l} = d;
    params_data_len = len;
    params_rd_mode  = rm;
    params_wr_mode  = wm;
  endtask

  // Launches a transfer and waits (bounded) for done. exp_lat < 0 skips the
  // latency check; retrig pulses start low/high while busy and scrambles the
  // source registers to show they were latched.
  task automatic run_xfer(input string name, input logic [63:0] s,
                          input logic [63:0] d, input logic [31:0] len,
                          input bit rm, input bit wm, input int exp_lat,
                          input bit retrig, input int exp_bursts);
    int k;
    int rd0, wr0;
    bit seen;
    rd0 = rd_hs_cnt; wr0 = wr_hs_cnt;
    @(posedge clk); #1;
    set_params(s, d, len, rm, wm);
    params_start = 1'b1;
    k = 0; seen = 1'b0;
    while (k < 2000 && !seen) begin
      @(posedge clk); k++;
      @(negedge clk);
      if (k == 1) begin
        chk({name, "_busy_start"}, 64'(busy), 64'd1);
        chk({name, "_done_clr"}, 64'(params_data_done), 64'd0);
      end
      if (retrig && k == 3) params_start = 1'b0;
      if (retrig && k == 5) begin
        params_start = 1'b1;
        params_saddr_l = 32'hDEAD_0000;
      end
      if (params_data_done) seen = 1'b1;
    end
    if (!seen) begin
      n_cmp++; n_err++;
      $display("FAIL %s_timeout: got no done after %0d cycles, expected done", name, k);
    end else begin
      if (exp_lat >= 0) chk({name, "_latency"}, 64'(k), 64'(exp_lat));
      chk({name, "_busy_end"}, 64'(busy), 64'd0);
    end
    chk({name, "_rd_count"}, 64'(rd_hs_cnt - rd0), 64'(exp_bursts));
    chk({name, "_wr_count"}, 64'(wr_hs_cnt - wr0), 64'(exp_bursts));
    chk({name, "_rdq_left"}, 64'(exp_rd_q.size()), 64'd0);
    chk({name, "_wrq_left"}, 64'(exp_wr_q.size()), 64'd0);
    @(posedge clk); #1;
    params_start = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got simulation still running, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int k;
    rst = 1'b1;
    params_start = 1'b0;
    set_params(64'd0, 64'd0, 32'd0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_idle("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Single full burst, minimum latency.
    push_cmd(64'h1000, 64'h2000, 256);
    run_xfer("t1", 64'h1000, 64'h2000, 32'h100, 1'b0, 1'b0, 7, 1'b0, 1);
    chk("t1_done_sticky", 64'(params_data_done), 64'd1);

    // Source boundary split; retrigger while busy must be ignored.
    push_cmd(64'h0FF0, 64'h5000, 32'h10);
    push_cmd(64'h1000, 64'h5010, 32'h100);
    push_cmd(64'h1100, 64'h5110, 32'h100);
    push_cmd(64'h1200, 64'h5210, 32'hF0);
    run_xfer("t2", 64'h0FF0, 64'h5000, 32'h300, 1'b0, 1'b0, -1, 1'b1, 4);
`ifdef MFUNC_DMA_PERF_EN
    chk("t2_perf_bursts", 64'(perf_bursts), 64'd4);
`endif

    // Fixed source.
    push_cmd(64'h8000, 64'h9000, 256);
    push_cmd(64'h8000, 64'h9100, 256);
    push_cmd(64'h8000, 64'h9200, 32'h50);
    run_xfer("t3", 64'h8000, 64'h9000, 32'h250, 1'b1, 1'b0, -1, 1'b0, 3);

    // Zero length: no commands, done two cycles after the edge.
    run_xfer("t4", 64'h4000, 64'h6000, 32'h0, 1'b0, 1'b0, 2, 1'b0, 0);

    // Fixed destination near a boundary does not limit the burst.
    push_cmd(64'h100, 64'h3FFC, 32'h20);
    run_xfer("t5", 64'h100, 64'h3FFC, 32'h20, 1'b0, 1'b1, -1, 1'b0, 1);

    // Source address wraps modulo 2^64.
    push_cmd(64'hFFFF_FFFF_FFFF_FF00, 64'h7000, 256);
    push_cmd(64'h0,                   64'h7100, 256);
    run_xfer("t6", 64'hFFFF_FFFF_FFFF_FF00, 64'h7000, 32'h200, 1'b0, 1'b0,
             -1, 1'b0, 2);

    // Read ready stalled for five cycles: command must hold steady.
    rd_stall = 5;
    push_cmd(64'hA000, 64'hB000, 32'h40);
    run_xfer("t7", 64'hA000, 64'hB000, 32'h40, 1'b0, 1'b0, 12, 1'b0, 1);

    // Reset while waiting for the write completion.
    wr_done_block = 1'b1;
    push_cmd(64'h1000, 64'h2000, 32'h80);
    k = wr_hs_cnt;
    @(posedge clk); #1;
    set_params(64'h1000, 64'h2000, 32'h80, 1'b0, 1'b0);
    params_start = 1'b1;
    for (int i = 0; i < 50 && wr_hs_cnt == k; i++) @(negedge clk);
    chk("t8_wr_issued", 64'(wr_hs_cnt - k), 64'd1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_idle("t8_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    params_start = 1'b0;
    wr_done_block = 1'b0;
    @(posedge clk); #1;

    // Fresh transfer after reset completes normally.
    push_cmd(64'h1000, 64'h2000, 256);
    run_xfer("t9", 64'h1000, 64'h2000, 32'h100, 1'b0, 1'b0, 7, 1'b0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mfunc_dma_ctrl.md
Name: mfunc_dma_ctrl

Overview:
Transfer sequencer for the MFUNC copy engine. It takes the programmed transfer parameters from the MFUNC register block: start, 64-bit source, 64-bit destination, byte length and address modes. It splits the transfer into read/write burst command pairs and issues them to the read and write data movers. On completion it reports done back into the register block's status register.

Parameters:
MAX_BURST, 256, maximum bytes per burst; power of two, 16..4096
LEN_W, 13, width of burst length fields; must hold MAX_BURST
BOUNDARY, 4096, burst must not cross this address boundary in incrementing mode; power of two, ≥ MAX_BURST

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
params_start  in  1  start level from register; rising edge launches a transfer
params_saddr_l  in  32  source address [31:0]
params_saddr_h  in  32  source address [63:32]
params_daddr_l  in  32  destination address [31:0]
params_daddr_h  in  32  destination address [63:32]
params_data_len  in  32  transfer length, bytes
params_rd_mode  in  1  0 = incrementing source, 1 = fixed source
params_wr_mode  in  1  0 = incrementing destination, 1 = fixed destination
params_data_done  out  1  sticky completion flag
busy  out  1  transfer in progress
rd_cmd_valid  out  1  read burst command valid
rd_cmd_ready  in  1  read mover accepts command
rd_cmd_addr  out  64  read burst address
rd_cmd_len  out  LEN_W  read burst bytes, 1..MAX_BURST
rd_done  in  1  one-cycle pulse: current read burst landed in buffer
wr_cmd_valid  out  1  write burst command valid
wr_cmd_ready  in  1  write mover accepts command
wr_cmd_addr  out  64  write burst address
wr_cmd_len  out  LEN_W  write burst bytes, equals preceding rd_cmd_len
wr_done  in  1  one-cycle pulse: current write burst committed

Behaviour:
- Reset, synchronous on rst=1: FSM to IDLE. All outputs 0. Counters and address registers 0. Applies mid-transfer; in-flight mover commands are abandoned.
- start_edge = params_start & ~start_q. start_q is registered each cycle and reset to 0.
- FSM states: IDLE, CALC, RD_CMD, RD_WAIT, WR_CMD, WR_WAIT, DONE.
- IDLE: on start_edge, latch src={saddr_h,saddr_l}, dst={daddr_h,daddr_l}, remaining=data_len and both modes. Clear params_data_done. Go to CALC. If data_len==0, go directly to DONE.
- CALC, one cycle: blen = min(remaining, MAX_BURST, BOUNDARY - src%BOUNDARY [only if rd_mode=0], BOUNDARY - dst%BOUNDARY [only if wr_mode=0]). Register blen. Go to RD_CMD.
- RD_CMD: rd_cmd_valid=1 with addr=src, len=blen. Hold stable until rd_cmd_ready. Valid drops the cycle after the handshake. Then go to RD_WAIT.
- RD_WAIT: wait for rd_done, then go to WR_CMD. rd_done outside RD_WAIT is ignored.
- WR_CMD: same handshake as RD_CMD with addr=dst, len=blen. Then go to WR_WAIT.
- WR_WAIT: on wr_done, update remaining -= blen. src += blen if rd_mode=0, dst += blen if wr_mode=0; additions are 64-bit and wrap modulo 2^64. Go to CALC if remaining≠0, else DONE.
- DONE: one cycle. Set params_data_done=1 (sticky until next accepted start_edge or rst). Return to IDLE.
- busy=1 in every state except IDLE.
- start_edge while busy: ignored, not queued. Deasserting params_start mid-transfer has no effect. Register input changes mid-transfer have no effect because values are latched.
- Command throughput: at most one outstanding read and one outstanding write; they never overlap.
- Minimum latency, len ≤ MAX_BURST with immediate readies and done pulses: start_edge to params_data_done = 7 cycles.

Optional Feature:
MFUNC_DMA_PERF_EN: adds output perf_cycles[31:0] and perf_bursts[15:0].
- perf_cycles counts cycles with busy=1; perf_bursts counts completed write bursts.
- Both counters clear on an accepted start_edge, saturate at all-ones and hold after done.
- Without the macro these ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package mfunc_dma_pkg: FSM state enum, MAX_BURST/BOUNDARY default constants, and a burst-length min function.
- One natural sub-module: mfunc_dma_blen. It is combinational/registered CALC logic computing blen from remaining, src, dst and the modes, and is unit-testable separately.

Test Plan:
- src=0x1000, dst=0x2000, len=0x100, modes 0 -> one rd cmd (0x1000, 256) and one wr cmd (0x2000, 256); done set; busy drops.
- src=0x0FF0, dst=0x5000, len=0x300 -> bursts of 0x10 @0x0FF0, then 0x100 @0x1000, 0x100 @0x1100, 0xF0 @0x1200; wr addrs 0x5000, 0x5010, 0x5110, 0x5210.
- rd_mode=1, src=0x8000, len=0x250 -> three bursts, all rd_cmd_addr=0x8000, lens 256/256/0x50; dst increments.
- len=0 start -> no commands; done=1 within 2 cycles of edge. Second start_edge while busy -> ignored; command count unchanged.
- rd_cmd_ready held low 5 cycles -> addr/len stable throughout; single handshake only.
- rst asserted in WR_WAIT -> next cycle all outputs 0, IDLE. A fresh start then completes normally.
